// File: rtl/alu_iter_unit.sv
// -----------------------------------------------------------------------------
// alu_iter_unit
//   Handshaked ALU for the multicycle datapath. Add/sub/logic ops complete in
//   one cycle. Shifts either iterate SHIFT_STEP bits per cycle (default build)
//   or complete in one cycle through a barrel shifter when ALU_BARREL_SHIFT_EN
//   is defined. The control FSM stalls on busy/out_valid instead of assuming a
//   fixed latency.
//
//   Build option: `define ALU_BARREL_SHIFT_EN -> single-cycle barrel shifts,
//   SHIFT state never entered, SHIFT_STEP has no effect.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   flush               synchronous abort of the operation in flight
//   in_valid/in_ready   request handshake; in_ready high only in IDLE
//   op, a, b            opcode and operands (shifts use b[SHAMT_W-1:0])
//   out_valid/out_ready result handshake
//   result, flags       registered result and {zero,negative,carry,overflow}
//   busy                high while in SHIFT or DONE
// -----------------------------------------------------------------------------
package defs_pkg;
   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLL = 3'd5,
      ALU_SRL = 3'd6,
      ALU_SRA = 3'd7
   } alu_opcode_t;

   typedef struct packed {
      logic zero;
      logic negative;
      logic carry;
      logic overflow;
   } alu_flags_t;
endpackage

module alu_iter_unit
   import defs_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  alu_opcode_t       op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output alu_flags_t        flags,
   output logic              busy
);

   localparam int SHAMT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   alu_flags_t         flags_q, flags_d;

   logic [SHAMT_W-1:0] shamt_in;
   logic [WIDTH:0]     sum, diff;
   logic               add_ovf, sub_ovf;

   // Returns {last bit shifted out, shifted value}. With n==0 the carry is 0.
   // The extra guard bit catches the final bit to leave the word.
   function automatic logic [WIDTH:0] shift_by(input alu_opcode_t sop,
                                                input logic [WIDTH-1:0] v,
                                                input logic [SHAMT_W-1:0] n);
      logic [WIDTH:0] t;
      case (sop)
         ALU_SLL: begin
            t = {1'b0, v} << n;
            shift_by = t;
         end
         ALU_SRL: begin
            t = {v, 1'b0} >> n;
            shift_by = {t[0], t[WIDTH:1]};
         end
         default: begin
            t = $signed({v, 1'b0}) >>> n;
            shift_by = {t[0], t[WIDTH:1]};
         end
      endcase
   endfunction

   function automatic alu_flags_t mk_flags(input logic [WIDTH-1:0] r,
                                           input logic c, input logic v);
      alu_flags_t f;
      f.zero     = (r == '0);
      f.negative = r[WIDTH-1];
      f.carry    = c;
      f.overflow = v;
      return f;
   endfunction

   assign shamt_in = b[SHAMT_W-1:0];
   assign sum      = {1'b0, a} + {1'b0, b};
   assign diff     = {1'b0, a} - {1'b0, b};
   assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
   assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

`ifdef ALU_BARREL_SHIFT_EN
   logic [WIDTH:0] barrel;
   assign barrel = shift_by(op, a, shamt_in);
`else
   localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

   // Iterative shifter working set: value being shifted, bits still to go,
   // and the latched shift direction.
   logic [WIDTH-1:0]   work_q, work_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   alu_opcode_t        sop_q, sop_d;
   logic [SHAMT_W-1:0] step;
   logic [WIDTH:0]     stepped;

   assign step    = (rem_q > STEP) ? STEP : rem_q;
   assign stepped = shift_by(sop_q, work_q, step);
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      flags_d  = flags_q;
`ifndef ALU_BARREL_SHIFT_EN
      work_d   = work_q;
      rem_d    = rem_q;
      sop_d    = sop_q;
`endif
      if (flush) begin
         // Abort: result/flags keep their last completed value.
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  state_d = S_DONE;
                  case (op)
                     ALU_ADD: begin
                        result_d = sum[WIDTH-1:0];
                        flags_d  = mk_flags(sum[WIDTH-1:0], sum[WIDTH], add_ovf);
                     end
                     ALU_SUB: begin
                        // carry means "no borrow": a >= b unsigned
                        result_d = diff[WIDTH-1:0];
                        flags_d  = mk_flags(diff[WIDTH-1:0], ~diff[WIDTH], sub_ovf);
                     end
                     ALU_AND: begin
                        result_d = a & b;
                        flags_d  = mk_flags(a & b, 1'b0, 1'b0);
                     end
                     ALU_OR: begin
                        result_d = a | b;
                        flags_d  = mk_flags(a | b, 1'b0, 1'b0);
                     end
                     ALU_XOR: begin
                        result_d = a ^ b;
                        flags_d  = mk_flags(a ^ b, 1'b0, 1'b0);
                     end
                     default: begin
`ifdef ALU_BARREL_SHIFT_EN
                        result_d = barrel[WIDTH-1:0];
                        flags_d  = mk_flags(barrel[WIDTH-1:0], barrel[WIDTH], 1'b0);
`else
                        if (shamt_in == '0) begin
                           result_d = a;
                           flags_d  = mk_flags(a, 1'b0, 1'b0);
                        end else begin
                           state_d = S_SHIFT;
                           work_d  = a;
                           rem_d   = shamt_in;
                           sop_d   = op;
                        end
`endif
                     end
                  endcase
               end
            end
`ifndef ALU_BARREL_SHIFT_EN
            S_SHIFT: begin
               work_d = stepped[WIDTH-1:0];
               rem_d  = rem_q - step;
               // Final step: its shifted-out bit is the op's carry.
               if (rem_q == step) begin
                  state_d  = S_DONE;
                  result_d = stepped[WIDTH-1:0];
                  flags_d  = mk_flags(stepped[WIDTH-1:0], stepped[WIDTH], 1'b0);
               end
            end
`endif
            S_DONE: begin
               if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         flags_q  <= '0;
`ifndef ALU_BARREL_SHIFT_EN
         work_q   <= '0;
         rem_q    <= '0;
         sop_q    <= ALU_ADD;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
`ifndef ALU_BARREL_SHIFT_EN
         work_q   <= work_d;
         rem_q    <= rem_d;
         sop_q    <= sop_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = result_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_alu_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_iter_unit
//   Two instances (SHIFT_STEP=1 and SHIFT_STEP=2) share one stimulus stream.
//   Expected result, flags and latency come from an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_iter_unit;
   import defs_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   alu_opcode_t op;
   logic [15:0] a, b;
   logic        rdy1, rdy2, ov1, ov2, busy1, busy2;
   logic [15:0] res1, res2;
   logic [3:0]  fl1, fl2;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_iter_unit #(.WIDTH(16), .SHIFT_STEP(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
      .op(op), .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
      .result(res1), .flags(fl1), .busy(busy1));

   alu_iter_unit #(.WIDTH(16), .SHIFT_STEP(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
      .op(op), .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready),
      .result(res2), .flags(fl2), .busy(busy2));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: plain arithmetic on the architectural rules.
   function automatic void model(input alu_opcode_t o, input logic [15:0] x, input logic [15:0] y,
                                 input int stepw, output logic [15:0] r, output logic [3:0] f,
                                 output int lat);
      int s, sx, sy, full, t;
      logic c, v;
      s  = int'(y) % 16;
      sx = int'($signed(x));
      sy = int'($signed(y));
      c  = 1'b0;
      v  = 1'b0;
      lat = 1;
      case (o)
         ALU_ADD: begin
            full = int'(x) + int'(y);
            r = full[15:0];
            c = (full > 65535);
            v = (sx + sy > 32767) || (sx + sy < -32768);
         end
         ALU_SUB: begin
            full = int'(x) - int'(y);
            r = full[15:0];
            c = (x >= y);
            v = (sx - sy > 32767) || (sx - sy < -32768);
         end
         ALU_AND: r = x & y;
         ALU_OR:  r = x | y;
         ALU_XOR: r = x ^ y;
         ALU_SLL: begin
            t = int'(x) * (1 << s);
            r = t[15:0];
            c = (s != 0) && (((int'(x) >> (16 - s)) & 1) != 0);
         end
         ALU_SRL: begin
            r = x >> s;
            c = (s != 0) && (((int'(x) >> (s - 1)) & 1) != 0);
         end
         default: begin
            t = sx >>> s;
            r = t[15:0];
            c = (s != 0) && (((sx >>> (s - 1)) & 1) != 0);
         end
      endcase
`ifndef ALU_BARREL_SHIFT_EN
      if (o inside {ALU_SLL, ALU_SRL, ALU_SRA} && s != 0)
         lat = 1 + (s + stepw - 1) / stepw;
`endif
      f = {r == 16'h0, r[15], c, v};
   endfunction

   // Issue one op with out_ready high and check both instances.
   task automatic do_op(input alu_opcode_t o, input logic [15:0] x, input logic [15:0] y,
                        input string tag);
      logic [15:0] er1, er2, gr1, gr2;
      logic [3:0]  ef1, ef2, gf1, gf2;
      logic        gb1, gb2;
      int          el1, el2, l1, l2, cnt;
      model(o, x, y, 1, er1, ef1, el1);
      model(o, x, y, 2, er2, ef2, el2);
      l1 = -1; l2 = -1; gr1 = 'x; gr2 = 'x; gf1 = 'x; gf2 = 'x; gb1 = 'x; gb2 = 'x;
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cnt = 0;
      while ((l1 < 0 || l2 < 0) && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (ov1 && l1 < 0) begin l1 = cnt; gr1 = res1; gf1 = fl1; gb1 = busy1; end
         if (ov2 && l2 < 0) begin l2 = cnt; gr2 = res2; gf2 = fl2; gb2 = busy2; end
      end
      chk({tag, " res s1"},  32'(gr1), 32'(er1));
      chk({tag, " flg s1"},  32'(gf1), 32'(ef1));
      chk({tag, " lat s1"},  l1, el1);
      chk({tag, " res s2"},  32'(gr2), 32'(er2));
      chk({tag, " flg s2"},  32'(gf2), 32'(ef2));
      chk({tag, " lat s2"},  l2, el2);
      chk({tag, " busy"},    {gb1, gb2}, 2'b11);
      cnt = 0;
      while (!(rdy1 && rdy2) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, " idle"}, {rdy1, rdy2}, 2'b11);
   endtask

   logic [15:0] er, keep;
   logic [3:0]  ef, keepf;
   int          el;
   logic        saw_valid;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = ALU_ADD; a = '0; b = '0;
      #1;
      chk("reset out_valid", {ov1, ov2}, 2'b00);
      chk("reset result", {res1, res2}, 32'h0);
      chk("reset flags", {fl1, fl2}, 8'h0);
      chk("reset busy", {busy1, busy2}, 2'b00);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after reset", {rdy1, rdy2}, 2'b11);

      // Directed corner cases
      do_op(ALU_ADD, 16'h7FFF, 16'h0001, "add ovf");
      do_op(ALU_ADD, 16'hFFFF, 16'h0001, "add carry");
      do_op(ALU_SUB, 16'h0005, 16'h0005, "sub eq");
      do_op(ALU_SUB, 16'h0000, 16'h0001, "sub borrow");
      do_op(ALU_SUB, 16'h8000, 16'h0001, "sub ovf");
      do_op(ALU_XOR, 16'hA5A5, 16'hA5A5, "xor zero");
      do_op(ALU_SRL, 16'h0006, 16'h0002, "srl 2");
      do_op(ALU_SRA, 16'h8001, 16'h0013, "sra 3");
      do_op(ALU_SLL, 16'h0001, 16'h000F, "sll 15");
      do_op(ALU_SLL, 16'h1234, 16'h0010, "sll 0");
      do_op(ALU_SRA, 16'h8000, 16'h000F, "sra 15");

      // Backpressure: result held, requests ignored while DONE
      model(ALU_ADD, 16'h1234, 16'h0FF0, 1, er, ef, el);
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; op = ALU_ADD; a = 16'h1234; b = 16'h0FF0;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp first valid", {ov1, ov2}, 2'b11);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; op = ALU_SUB; a = 16'h0000; b = 16'h0001;
         @(negedge clk);
         chk("bp valid held", {ov1, ov2}, 2'b11);
         chk("bp result held", {res1, res2}, {er, er});
         chk("bp flags held", {fl1, fl2}, {ef, ef});
         chk("bp in_ready low", {rdy1, rdy2}, 2'b00);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release ready", {rdy1, rdy2}, 2'b11);
      chk("bp release valid", {ov1, ov2}, 2'b00);
      chk("bp result kept", {res1, res2}, {er, er});

`ifndef ALU_BARREL_SHIFT_EN
      // Flush mid-shift: no completion, old result kept
      keep = er; keepf = ef;
      @(negedge clk);
      in_valid = 1'b1; op = ALU_SLL; a = 16'h0001; b = 16'h000F;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush in_ready", {rdy1, rdy2}, 2'b11);
      chk("flush result", {res1, res2}, {keep, keep});
      chk("flush flags", {fl1, fl2}, {keepf, keepf});
      saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ov1 || ov2) saw_valid = 1'b1;
      end
      chk("flush no valid", saw_valid, 1'b0);

      // Reset mid-shift clears outputs immediately
      @(negedge clk);
      in_valid = 1'b1; op = ALU_SLL; a = 16'h0001; b = 16'h000F;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst mid result", {res1, res2}, 32'h0);
      chk("rst mid flags", {fl1, fl2}, 8'h0);
      chk("rst mid valid", {ov1, ov2}, 2'b00);
      chk("rst mid busy", {busy1, busy2}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst mid ready", {rdy1, rdy2}, 2'b11);
`endif

      // Random ops; b fully random so shift amounts ignore upper bits
      for (int i = 0; i < 60; i++) begin
         do_op(alu_opcode_t'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
